riscv_muldiv: RTL and testbench
===============================

// Module: riscv_muldiv
// PURPOSE
// - Iterative RV32M multiply/divide unit, parametrised in datapath width; EX-stage co-unit of the pipelined core.
// - Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU under a start/busy/done handshake.
// - Pipeline stalls on busy and writes back result on done.
// - Flush input lets branch/exception logic kill an in-flight op.
// PARAMETERS
// - DATA_W  32  operand/result width; legal >=8, even
// PORTS
// - clk     in   1       clock; single clock domain, all state updates on posedge
// - reset   in   1       synchronous, active-high; sampled on posedge clk
// - start   in   1       request; accepted only in IDLE
// - flush   in   1       synchronous kill of in-flight op
// - funct3  in   3       000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
// - op_a    in   DATA_W  rs1 operand (multiplicand/dividend)
// - op_b    in   DATA_W  rs2 operand (multiplier/divisor)
// - busy    out  1       op in flight (CALC or DONE); pipeline stalls while high
// - done    out  1       one-cycle pulse; result valid in this cycle
// - result  out  DATA_W  final value; held until next done
// BEHAVIOUR
// - Reset: state=IDLE; busy=0, done=0, result=0, counter=0. Reset mid-op discards op, no done.
// - FSM IDLE->CALC->DONE->IDLE.
//   - IDLE: start=1 latches funct3, operand magnitudes, result sign; cnt=0; ->CALC.
//     Special case detected at accept -> DONE directly.
//   - CALC: one radix-2 step per cycle. Mul: shift-add into 2*DATA_W accumulator.
//     Div: restoring subtract-shift. At cnt==DATA_W-1 ->DONE.
//   - DONE: apply sign fix; drive result, done=1; ->IDLE.
// - Latency: start high in cycle 0 -> done high in cycle DATA_W+1 (33 for DATA_W=32).
//   Special cases: done in cycle 1.
// - start while busy: ignored, no queueing. Back-to-back: next start accepted in cycle after done.
// - flush (any state): ->IDLE next edge, no done, result unchanged.
//   flush and start in same IDLE cycle: flush wins, op not accepted.
// - Signedness: MUL/MULH/DIV/REM signed x signed; MULHSU signed a x unsigned b; others unsigned.
//   - Signed ops: two's-complement magnitudes, unsigned core, negate at DONE.
// - Result select: MUL low DATA_W of product; MULH* high DATA_W of product.
//   REM sign follows dividend.
// - Divide by zero: DIV/DIVU = all ones; REM/REMU = op_a.
// - Signed overflow (op_a=-2^(W-1), op_b=-1): DIV = op_a, REM = 0.
// - No exceptions raised; all results per RISC-V M spec.
// CONFIGURATION
// - `RISCV_FAST_MUL_EN defined: MUL* use single-cycle DATA_W x DATA_W product in accept cycle.
//   Goes IDLE->DONE; done in cycle 1. Divide stays iterative.
// - Undefined: all ops iterative as above; no hardware multiplier inferred.
// STRUCTURE
// - riscv_muldiv_pkg: funct3 op enum, FSM state enum (IDLE/CALC/DONE), is_signed_a/b and is_div helper functions.
// - One sub-module: riscv_div_step.
//   Combinational restoring-divide step: {rem,quo} in -> out, DATA_W parametrised.
// - Multiply accumulate, sign handling and FSM stay in top.
// TESTING (DATA_W=32, macro undefined unless noted)
// - MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB. busy cycles 1..33, done cycle 33 only.
// - High products, op_a=op_b=0xFFFFFFFF:
//   MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
// - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
// - Special cases, each with done in cycle 1:
//   DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
// - DIVU started; start re-pulsed cycle 5 with other operands -> ignored.
//   flush in cycle 10 -> busy=0 cycle 11, no done, result unchanged. New MUL 3x4 -> 12.
// - reset asserted mid-MULH -> busy/done/result=0 next cycle.
//   With `RISCV_FAST_MUL_EN: MUL 6x7 -> 42 with done in cycle 1.

Source files
------------

// File: rtl/riscv_muldiv_pkg.sv
// rtl/riscv_muldiv_pkg.sv - op/state enums and operand-class helpers for the RV32M mul/div unit
package riscv_muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   function automatic logic is_signed_a(op_e op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic is_signed_b(op_e op);
      return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
   endfunction

   function automatic logic is_div(op_e op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic is_rem(op_e op);
      return op inside {OP_REM, OP_REMU};
   endfunction

endpackage

// File: rtl/riscv_div_step.sv
// rtl/riscv_div_step.sv - one combinational restoring-divide step on a {rem,quo} pair
module riscv_div_step #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem_in,
   input  logic [DATA_W-1:0] quo_in,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] rem_out,
   output logic [DATA_W-1:0] quo_out
);

   logic [DATA_W:0] shifted;
   logic [DATA_W:0] diff;
   logic            fits;

   // rem < divisor on entry, so a successful subtract always fits back into DATA_W bits
   always_comb begin
      shifted = {rem_in, quo_in[DATA_W-1]};
      diff    = shifted - {1'b0, divisor};
      fits    = ~diff[DATA_W];
      rem_out = fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
      quo_out = {quo_in[DATA_W-2:0], fits};
   end

endmodule

// File: rtl/riscv_muldiv.sv
// rtl/riscv_muldiv.sv - iterative RV32M multiply/divide unit; RISCV_FAST_MUL_EN selects a single-cycle multiplier
module riscv_muldiv
   import riscv_muldiv_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              flush,
   input  logic [2:0]        funct3,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

   state_e                  state_q, state_d;
   op_e                     op_q;
   logic [2*DATA_W-1:0]     acc_q;
   logic [DATA_W-1:0]       mcand_q;
   logic                    neg_lo_q, neg_hi_q, special_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [DATA_W-1:0]       result_q;

   op_e                     op_in;
   logic                    a_neg, b_neg;
   logic [DATA_W-1:0]       a_mag, b_mag;
   logic                    div_zero, div_ovf, special_in, short_path;
   logic [DATA_W-1:0]       special_val;
   logic [2*DATA_W-1:0]     acc_init;
   logic [DATA_W-1:0]       mcand_init;

   assign op_in = op_e'(funct3);

   // Accept-time preparation: magnitudes, corner-case results and initial accumulator
   always_comb begin
      a_neg      = is_signed_a(op_in) && op_a[DATA_W-1];
      b_neg      = is_signed_b(op_in) && op_b[DATA_W-1];
      a_mag      = a_neg ? -op_a : op_a;
      b_mag      = b_neg ? -op_b : op_b;
      div_zero   = (op_b == '0);
      div_ovf    = (op_in == OP_DIV || op_in == OP_REM) && (op_a == MIN_NEG) && (op_b == '1);
      special_in = is_div(op_in) && (div_zero || div_ovf);
      if (div_zero)
         special_val = is_rem(op_in) ? op_a : '1;
      else
         special_val = is_rem(op_in) ? '0 : op_a;
      mcand_init = is_div(op_in) ? b_mag : a_mag;
      if (special_in)
         acc_init = {{DATA_W{1'b0}}, special_val};
      else if (is_div(op_in))
         acc_init = {{DATA_W{1'b0}}, a_mag};
      else
         acc_init = {{DATA_W{1'b0}}, b_mag};
`ifdef RISCV_FAST_MUL_EN
      short_path = special_in || !is_div(op_in);
      if (!is_div(op_in))
         acc_init = {{DATA_W{1'b0}}, a_mag} * {{DATA_W{1'b0}}, b_mag};
`else
      short_path = special_in;
`endif
   end

   logic [DATA_W:0]         mul_sum;
   logic [DATA_W-1:0]       div_rem, div_quo;
   logic [2*DATA_W-1:0]     acc_step;

   riscv_div_step #(.DATA_W(DATA_W)) u_div_step (
      .rem_in  (acc_q[2*DATA_W-1:DATA_W]),
      .quo_in  (acc_q[DATA_W-1:0]),
      .divisor (mcand_q),
      .rem_out (div_rem),
      .quo_out (div_quo)
   );

   // Multiplier sits in the low half and is consumed LSB-first while the product shifts in from the top
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      acc_step = is_div(op_q) ? {div_rem, div_quo} : {mul_sum, acc_q[DATA_W-1:1]};
   end

   logic [2*DATA_W-1:0]     prod_fix;
   logic [DATA_W-1:0]       quo_fix, rem_fix, fixed;

   always_comb begin
      prod_fix = neg_lo_q ? -acc_q : acc_q;
      quo_fix  = neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
      rem_fix  = neg_hi_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
      if (special_q)
         fixed = acc_q[DATA_W-1:0];
      else if (is_div(op_q))
         fixed = is_rem(op_q) ? rem_fix : quo_fix;
      else if (op_q == OP_MUL)
         fixed = prod_fix[DATA_W-1:0];
      else
         fixed = prod_fix[2*DATA_W-1:DATA_W];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = short_path ? DONE : CALC;
         CALC:    if (cnt_q == CNT_W'(DATA_W-1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush)
         state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q      <= OP_MUL;
         acc_q     <= '0;
         mcand_q   <= '0;
         neg_lo_q  <= 1'b0;
         neg_hi_q  <= 1'b0;
         special_q <= 1'b0;
         cnt_q     <= '0;
         result_q  <= '0;
      end else if (!flush) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_q      <= op_in;
                  acc_q     <= acc_init;
                  mcand_q   <= mcand_init;
                  neg_lo_q  <= a_neg ^ b_neg;
                  neg_hi_q  <= a_neg;
                  special_q <= special_in;
                  cnt_q     <= '0;
               end
            end
            CALC: begin
               acc_q <= acc_step;
               cnt_q <= cnt_q + CNT_W'(1);
            end
            DONE:    result_q <= fixed;
            default: ;
         endcase
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE) && !flush;
   assign result = done ? fixed : result_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// tb/tb_riscv_muldiv.sv - directed bench for riscv_muldiv (DATA_W=32), honours RISCV_FAST_MUL_EN
module tb_riscv_muldiv;

`ifdef RISCV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b;
   logic        busy, done;
   logic [31:0] result;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] last_exp = 32'h0;

   riscv_muldiv #(.DATA_W(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .flush  (flush),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int   n;
      logic seen;
      funct3 = f;
      op_a   = a;
      op_b   = b;
      start  = 1'b1;
      #1;
      chk({tag, ":busy_c0"}, 32'(busy), 32'd0);
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 100) begin
         tick();
         start = 1'b0;
         #1;
         n++;
         if (done === 1'b1)
            seen = 1'b1;
         else
            chk({tag, ":busy_calc"}, 32'(busy), 32'd1);
      end
      chk({tag, ":latency"}, 32'(n), 32'(exp_lat));
      chk({tag, ":result"}, result, exp_res);
      chk({tag, ":busy_done"}, 32'(busy), 32'd1);
      tick();
      #1;
      chk({tag, ":done_after"}, 32'(done), 32'd0);
      chk({tag, ":busy_after"}, 32'(busy), 32'd0);
      chk({tag, ":result_held"}, result, exp_res);
      last_exp = exp_res;
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      flush  = 1'b0;
      funct3 = 3'b000;
      op_a   = 32'h0;
      op_b   = 32'h0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("reset:busy", 32'(busy), 32'd0);
      chk("reset:done", 32'(done), 32'd0);
      chk("reset:result", result, 32'h0);

      do_op("mul_7x_m3", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
      do_op("mulhu_ff", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
      do_op("mulh_ff", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT);
      do_op("mulhsu_ff", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);
      do_op("div_m7_2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
      do_op("rem_m7_2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
      do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
      do_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
      do_op("div_by0", 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
      do_op("rem_by0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
      do_op("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
      do_op("remu_by0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
      do_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      do_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
      do_op("divu_min_max", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
      do_op("remu_min_max", 3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);

      funct3 = 3'b101;
      op_a   = 32'd1000;
      op_b   = 32'd10;
      start  = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         tick();
         start = (c == 5);
         flush = (c == 10);
         if (c == 5) begin
            funct3 = 3'b000;
            op_a   = 32'd9;
            op_b   = 32'd9;
         end
         #1;
         chk("flush:no_done", 32'(done), 32'd0);
         chk("flush:busy", 32'(busy), (c <= 10) ? 32'd1 : 32'd0);
      end
      chk("flush:result_kept", result, last_exp);
      tick();
      #1;
      chk("flush:no_queue", 32'(busy), 32'd0);

      funct3 = 3'b000;
      op_a   = 32'd3;
      op_b   = 32'd4;
      start  = 1'b1;
      flush  = 1'b1;
      tick();
      start = 1'b0;
      flush = 1'b0;
      #1;
      chk("flush_start:busy", 32'(busy), 32'd0);
      chk("flush_start:done", 32'(done), 32'd0);

      do_op("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, MUL_LAT);
      do_op("mul_6x7", 3'b000, 32'd6, 32'd7, 32'd42, MUL_LAT);

      funct3 = 3'b001;
      op_a   = 32'h40000000;
      op_b   = 32'd8;
      start  = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("rst_mid:busy", 32'(busy), 32'd0);
      chk("rst_mid:done", 32'(done), 32'd0);
      chk("rst_mid:result", result, 32'h0);
      for (int c = 0; c < 40; c++) begin
         tick();
         if (done === 1'b1)
            chk("rst_mid:late_done", 32'(done), 32'd0);
      end

      do_op("mulh_post_rst", 3'b001, 32'h40000000, 32'd8, 32'd2, MUL_LAT);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
